// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   UART_N        : byte width carried by the UART datapath.
//   RX_FIFO_DEPTH : default number of entries in the receive buffer.
//   clog2()       : constant-friendly ceiling log2 for pointer sizing.
package uart_pkg;

    localparam int UART_N        = 8;
    localparam int RX_FIFO_DEPTH = 16;

    // Smallest w such that (1 << w) >= value.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between uart_rx, the receive FIFO and its consumer.
//   i_data/i_valid   : byte and valid from uart_rx (push on valid rising edge)
//   i_rd             : consumer pop request
//   i_clr_overrun    : synchronous clear of the sticky overrun flag
//   o_data/o_valid   : head-of-queue byte, first-word-fall-through
//   o_full/o_count   : occupancy status
//   o_overrun        : sticky "byte dropped while full"
// slave  : the FIFO side.  master : the producer/consumer side.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int N     = UART_N,
    parameter int DEPTH = RX_FIFO_DEPTH
);

    localparam int ADDR_W = clog2(DEPTH);

    logic [N-1:0]    i_data;
    logic            i_valid;
    logic            i_rd;
    logic            i_clr_overrun;
    logic [N-1:0]    o_data;
    logic            o_valid;
    logic            o_full;
    logic [ADDR_W:0] o_count;
    logic            o_overrun;

    modport slave (
        input  i_data, i_valid, i_rd, i_clr_overrun,
        output o_data, o_valid, o_full, o_count, o_overrun
    );

    modport master (
        output i_data, i_valid, i_rd, i_clr_overrun,
        input  o_data, o_valid, o_full, o_count, o_overrun
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x N register array for the receive FIFO.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : mem[raddr]
// Storage is not reset; contents are meaningful only where the owner's
// pointers say so.
module fifo_mem #(
    parameter int N      = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [N-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [N-1:0]      rdata
);

    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer between uart_rx and the operand/opcode logic.
// Captures one byte per rising edge of i_valid, holds up to DEPTH bytes in
// arrival order and presents the oldest first-word-fall-through.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : uart_rx_fifo_if.slave (see interface header for signal list)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int N     = UART_N,
    parameter int DEPTH = RX_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    uart_rx_fifo_if.slave bus
);

    localparam int              ADDR_W     = clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic              valid_d;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              overrun;

    logic              full;
    logic              not_empty;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              overrun_set;
    logic [N-1:0]      head_data;

    assign full      = (count == FULL_COUNT);
    assign not_empty = (count != '0);

    // uart_rx may hold valid as a level; only its rising edge is a new byte.
    assign push_req = bus.i_valid & ~valid_d;
    assign pop      = bus.i_rd & not_empty;
    // A pop in the same cycle frees a slot, so a full queue still accepts.
    assign push        = push_req & (~full | pop);
    assign overrun_set = push_req & full & ~pop;

    fifo_mem #(
        .N      (N),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.i_data),
        .raddr (rd_ptr),
        .rdata (head_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_d <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            valid_d <= bus.i_valid;

            // Pointers are exactly ADDR_W bits wide, so +1 wraps modulo DEPTH.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Set has priority over a same-cycle clear.
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (bus.i_clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    // Head byte is masked while empty so stale storage never leaks out.
    assign bus.o_data    = not_empty ? head_data : '0;
    assign bus.o_valid   = not_empty;
    assign bus.o_full    = full;
    assign bus.o_count   = count;
    assign bus.o_overrun = overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int N      = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.N(N), .DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.N(N), .DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a plain queue of bytes plus the sticky flag.
    logic [7:0] model_q [$];
    bit         model_ovr;
    bit         prev_valid;

    // Advance one clock; update the model from the inputs seen at the edge.
    task automatic step();
        bit rise;
        bit do_pop;
        bit set;
        @(posedge clk);
        if (reset) begin
            rise   = bus.i_valid && !prev_valid;
            do_pop = bus.i_rd && (model_q.size() > 0);
            set    = 1'b0;
            if (rise && model_q.size() == DEPTH && !do_pop) set = 1'b1;
            if (do_pop) void'(model_q.pop_front());
            if (rise && !set) model_q.push_back(bus.i_data);
            if (set) model_ovr = 1'b1;
            else if (bus.i_clr_overrun) model_ovr = 1'b0;
            prev_valid = bus.i_valid;
        end
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.i_data  = b;
        bus.i_valid = 1'b1;
        step();
        bus.i_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        // Reset state from power-up.
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== '0 || bus.o_overrun !== 1'b0 ||
            bus.o_full !== 1'b0 || bus.o_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_init: valid=%b count=%0d ovr=%b full=%b data=%h required 0/0/0/0/00",
                     bus.o_valid, bus.o_count, bus.o_overrun, bus.o_full, bus.o_data);
        end
        reset = 1'b1;
        step();
        // Traffic, then asynchronous reset mid-operation.
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        #2;
        reset = 1'b0;
        model_q.delete();
        model_ovr  = 1'b0;
        prev_valid = 1'b0;
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== '0 || bus.o_overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: valid=%b count=%0d ovr=%b required 0/0/0",
                     bus.o_valid, bus.o_count, bus.o_overrun);
        end
        step();
        reset = 1'b1;
        bus.i_data  = 8'hA5;
        bus.i_valid = 1'b1;
        step();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 8'hA5 || bus.o_count !== 5'd1) begin
            failures++;
            $display("FAIL reset_first_push: valid=%b data=%h count=%0d required 1/a5/1",
                     bus.o_valid, bus.o_data, bus.o_count);
        end
        bus.i_valid = 1'b0;
        bus.i_rd    = 1'b1;
        step();
        bus.i_rd    = 1'b0;
        // i_valid already high when reset releases gives exactly one push.
        reset       = 1'b0;
        prev_valid  = 1'b0;
        model_q.delete();
        bus.i_data  = 8'h77;
        bus.i_valid = 1'b1;
        step();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (bus.o_count !== 5'd1 || bus.o_data !== 8'h77) begin
            failures++;
            $display("FAIL reset_valid_high: count=%0d data=%h required 1/77", bus.o_count, bus.o_data);
        end
        bus.i_valid = 1'b0;
        bus.i_rd    = 1'b1;
        step();
        bus.i_rd    = 1'b0;
        step();
    endtask

    task automatic test_fwft();
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        bus.i_rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.o_data !== 8'(i + 1) || bus.o_count !== 5'(3 - i) || bus.o_valid !== 1'b1) begin
                failures++;
                $display("FAIL fwft_pop%0d: data=%h count=%0d valid=%b required %h/%0d/1",
                         i, bus.o_data, bus.o_count, bus.o_valid, i + 1, 3 - i);
            end
            step();
        end
        bus.i_rd = 1'b0;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 5'd0) begin
            failures++;
            $display("FAIL fwft_empty: valid=%b count=%0d required 0/0", bus.o_valid, bus.o_count);
        end
        // Pop while empty plus push: pop ignored, one entry results.
        bus.i_rd    = 1'b1;
        bus.i_data  = 8'h9E;
        bus.i_valid = 1'b1;
        step();
        bus.i_rd    = 1'b0;
        bus.i_valid = 1'b0;
        checks++;
        if (bus.o_count !== 5'd1 || bus.o_data !== 8'h9E) begin
            failures++;
            $display("FAIL empty_push_pop: count=%0d data=%h required 1/9e", bus.o_count, bus.o_data);
        end
        bus.i_rd = 1'b1;
        step();
        bus.i_rd = 1'b0;
    endtask

    task automatic test_level_valid();
        bus.i_data  = 8'h3C;
        bus.i_valid = 1'b1;
        repeat (10) step();
        bus.i_valid = 1'b0;
        step();
        checks++;
        if (bus.o_count !== 5'd1 || bus.o_data !== 8'h3C) begin
            failures++;
            $display("FAIL level_valid: count=%0d data=%h required 1/3c", bus.o_count, bus.o_data);
        end
        bus.i_rd = 1'b1;
        step();
        bus.i_rd = 1'b0;
    endtask

    task automatic test_full_overrun();
        for (int i = 0; i <= 16; i++) push_byte(8'(i));
        checks++;
        if (bus.o_full !== 1'b1 || bus.o_count !== 5'd16 || bus.o_overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set: full=%b count=%0d ovr=%b required 1/16/1",
                     bus.o_full, bus.o_count, bus.o_overrun);
        end
        // Set and clear in the same cycle: set wins.
        bus.i_data        = 8'hEE;
        bus.i_valid       = 1'b1;
        bus.i_clr_overrun = 1'b1;
        step();
        bus.i_valid = 1'b0;
        checks++;
        if (bus.o_overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set_wins: ovr=%b required 1", bus.o_overrun);
        end
        step();
        bus.i_clr_overrun = 1'b0;
        checks++;
        if (bus.o_overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear: ovr=%b required 0", bus.o_overrun);
        end
        bus.i_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.o_data !== 8'(i) || bus.o_valid !== 1'b1) begin
                failures++;
                $display("FAIL overrun_drain%0d: data=%h valid=%b required %h/1",
                         i, bus.o_data, bus.o_valid, i);
            end
            step();
        end
        bus.i_rd = 1'b0;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 5'd0) begin
            failures++;
            $display("FAIL overrun_empty: valid=%b count=%0d required 0/0", bus.o_valid, bus.o_count);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        bus.i_data  = 8'h55;
        bus.i_valid = 1'b1;
        bus.i_rd    = 1'b1;
        step();
        bus.i_valid = 1'b0;
        bus.i_rd    = 1'b0;
        checks++;
        if (bus.o_count !== 5'd16 || bus.o_overrun !== 1'b0 || bus.o_full !== 1'b1) begin
            failures++;
            $display("FAIL full_push_pop: count=%0d ovr=%b full=%b required 16/0/1",
                     bus.o_count, bus.o_overrun, bus.o_full);
        end
        bus.i_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp_b;
            exp_b = (i < 15) ? 8'(i + 1) : 8'h55;
            checks++;
            if (bus.o_data !== exp_b) begin
                failures++;
                $display("FAIL full_pp_drain%0d: data=%h required %h", i, bus.o_data, exp_b);
            end
            step();
        end
        bus.i_rd = 1'b0;
    endtask

    task automatic test_wrap_random();
        logic [7:0] sent [$];
        int pushed = 0;
        int rcv    = 0;
        int iter   = 0;
        while ((pushed < 40 || model_q.size() > 0) && iter < 3000) begin
            iter++;
            bus.i_valid = 1'b0;
            if (pushed < 40 && !prev_valid && model_q.size() < 5 && $urandom_range(0, 1) == 1) begin
                bus.i_data  = 8'($urandom);
                bus.i_valid = 1'b1;
                sent.push_back(bus.i_data);
                pushed++;
            end
            bus.i_rd = ($urandom_range(0, 2) == 0);
            if (bus.i_rd && model_q.size() > 0) begin
                checks++;
                if (rcv >= sent.size() || bus.o_data !== sent[rcv]) begin
                    failures++;
                    $display("FAIL wrap_order%0d: data=%h required %h", rcv, bus.o_data,
                             (rcv < sent.size()) ? sent[rcv] : 8'h00);
                end
                rcv++;
            end
            step();
            checks++;
            if (bus.o_count !== (ADDR_W + 1)'(model_q.size()) ||
                bus.o_data !== ((model_q.size() > 0) ? model_q[0] : 8'h00) ||
                bus.o_overrun !== model_ovr) begin
                failures++;
                $display("FAIL wrap_state: count=%0d data=%h ovr=%b required %0d/%h/%b",
                         bus.o_count, bus.o_data, bus.o_overrun, model_q.size(),
                         (model_q.size() > 0) ? model_q[0] : 8'h00, model_ovr);
            end
        end
        bus.i_valid = 1'b0;
        bus.i_rd    = 1'b0;
        checks++;
        if (rcv != 40 || model_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_complete: received=%0d left=%0d required 40/0", rcv, model_q.size());
        end
    endtask

    initial begin
        bus.i_data        = '0;
        bus.i_valid       = 1'b0;
        bus.i_rd          = 1'b0;
        bus.i_clr_overrun = 1'b0;
        model_ovr         = 1'b0;
        prev_valid        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_fwft();
        test_level_valid();
        test_full_overrun();
        test_full_push_pop();
        test_wrap_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer between uart_rx and the operand/opcode interface logic. It captures each byte uart_rx delivers, stores up to DEPTH bytes in arrival order, and presents them first-word-fall-through to the consumer. Back-to-back frames are therefore not lost while the consumer is busy waiting on the ALU or the transmitter. Overflow is reported through a sticky flag.

Parameters:
N, 8, data width in bits; matches the UART byte width.
DEPTH, 16, number of entries; must be a power of two, 2 or greater.
ADDR_W, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
i_data  input  N  received byte from uart_rx (data_out).
i_valid  input  1  uart_rx valid; level or pulse, push on rising edge only.
i_rd  input  1  consumer pop request; acts only when o_valid=1.
o_data  output  N  head-of-queue byte; valid while o_valid=1.
o_valid  output  1  queue not empty.
o_full  output  1  count == DEPTH.
o_count  output  ADDR_W+1  current occupancy, 0..DEPTH.
o_overrun  output  1  sticky; a byte was dropped because the queue was full.
i_clr_overrun  input  1  synchronous clear of o_overrun.

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, valid_d=0, o_overrun=0. Outputs go to o_valid=0, o_full=0, o_count=0, o_data=0. Storage contents are don't-care.
- Edge detect: valid_d is registered from i_valid. push_req = i_valid & ~valid_d. A level held high for many cycles yields exactly one push.
- push = push_req & (~o_full | pop). pop = i_rd & o_valid. i_rd while empty is ignored with no pointer change.
- On push: mem[wr_ptr] <= i_data; wr_ptr <= wr_ptr+1. Pointer wraps modulo DEPTH.
- On pop: rd_ptr <= rd_ptr+1, with modulo wrap.
- count: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- o_data = mem[rd_ptr], combinational from the registered pointer (FWFT).
- o_valid = (count != 0). o_full = (count == DEPTH). All flags derive from registered count.
- Latency: a byte pushed at edge k is visible on o_data with o_valid=1 after edge k, i.e. 1 cycle.
- Simultaneous push and pop when full: both occur. count stays DEPTH; the new byte is stored in the slot just freed.
- Simultaneous push and pop when empty: the pop is ignored because o_valid=0. The push occurs and count becomes 1. There is no bypass.
- Overrun: push_req & o_full & ~pop sets o_overrun=1 and drops the byte. Memory and pointers are unchanged.
- Clear: i_clr_overrun clears o_overrun. If a set and a clear occur in the same cycle, the set wins.
- Reset mid-operation clears the queue immediately; in-flight bytes are lost. valid_d resets to 0, so an i_valid already high when reset releases produces one push on the first edge.

Decomposition:
- Shared package uart_pkg holds: UART_N=8, RX_FIFO_DEPTH=16, and function clog2 if the toolflow lacks $clog2.
- One natural sub-module: fifo_mem, a DEPTH x N register array with a synchronous write port and an asynchronous read port.
- Pointer/count logic, the edge detector and the overrun flag stay in uart_rx_fifo.

Test Plan:
- Reset: drive reset=0 mid-traffic, then release. Required: o_valid=0, o_count=0, o_overrun=0; the next push of 0xA5 appears on o_data with o_valid=1 one cycle later.
- Ordering/FWFT: push 0x01,0x02,0x03, then pop three times. Required: o_data sequence 0x01,0x02,0x03; o_count steps 3,2,1,0; o_valid falls after the third pop.
- Level valid: hold i_valid=1 for 10 cycles with i_data=0x3C. Required: exactly one entry, o_count=1.
- Full/overrun: push 17 bytes 0x00..0x10 with no pops. Required: o_full=1, o_count=16, o_overrun=1; pops return 0x00..0x0F and 0x10 is absent. Asserting i_clr_overrun clears the flag.
- Full with simultaneous push and pop: fill with 0x00..0x0F, then push 0x55 while i_rd=1. Required: o_count stays 16, o_overrun=0; draining returns 0x01..0x0F then 0x55.
- Wrap-around: run 40 push/pop pairs at random gaps with occupancy kept at 5 or below. Required: output matches the input order, and pointers wrap past 15 without data loss.
